// File: rtl/fetch_unit_btb.sv
// Fetch PC generator with a direct-mapped BTB and 2-bit saturating counters.
// The lookup on o_pc_current sees only registered BTB state, so updates become visible one cycle later.
module fetch_unit_btb #(
  parameter int                    ADDR_WIDTH = 26,
  parameter int                    BTB_DEPTH  = 16,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
  parameter logic [1:0]            CTR_INIT   = 2'b10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_stall,
  input  logic                  i_load_we,
  input  logic [ADDR_WIDTH-1:0] i_load_pc,
  input  logic                  i_upd_valid,
  input  logic [ADDR_WIDTH-1:0] i_upd_pc,
  input  logic [ADDR_WIDTH-1:0] i_upd_target,
  input  logic                  i_upd_taken,
  output logic [ADDR_WIDTH-1:0] o_pc_current,
  output logic [ADDR_WIDTH-1:0] o_pc_next,
  output logic                  o_pred_taken,
  output logic [ADDR_WIDTH-1:0] o_pred_target
);

  localparam int IDX   = $clog2(BTB_DEPTH);
  localparam int TAG_W = ADDR_WIDTH - IDX - 2;
  localparam logic [ADDR_WIDTH-1:0] PC_STEP = ADDR_WIDTH'(4);

  logic [BTB_DEPTH-1:0]  valid;
  logic [TAG_W-1:0]      tag_mem    [BTB_DEPTH];
  logic [ADDR_WIDTH-1:0] target_mem [BTB_DEPTH];
  logic [1:0]            ctr_mem    [BTB_DEPTH];

  logic [IDX-1:0]   rd_idx;
  logic [TAG_W-1:0] rd_tag;
  logic             rd_hit;
  logic [IDX-1:0]   wr_idx;
  logic [TAG_W-1:0] wr_tag;
  logic             wr_hit;
  logic             unused_upd_low;

  // Byte offset of the resolved branch PC plays no part in indexing or tagging.
  assign unused_upd_low = ^i_upd_pc[1:0];

  always_comb begin
    rd_idx = o_pc_current[IDX+1:2];
    rd_tag = o_pc_current[ADDR_WIDTH-1:IDX+2];
    rd_hit = valid[rd_idx] && (tag_mem[rd_idx] == rd_tag);
    wr_idx = i_upd_pc[IDX+1:2];
    wr_tag = i_upd_pc[ADDR_WIDTH-1:IDX+2];
    wr_hit = valid[wr_idx] && (tag_mem[wr_idx] == wr_tag);
  end

  always_comb begin
    o_pred_taken  = rd_hit && ctr_mem[rd_idx][1];
    o_pred_target = o_pred_taken ? target_mem[rd_idx] : '0;
  end

  always_comb begin
    if (i_load_we)
      o_pc_next = i_load_pc;
    else if (i_stall)
      o_pc_next = o_pc_current;
    else if (o_pred_taken)
      o_pc_next = o_pred_target;
    else
      o_pc_next = o_pc_current + PC_STEP;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      o_pc_current <= RESET_PC;
    else
      o_pc_current <= o_pc_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      valid <= '0;
    else if (i_upd_valid && i_upd_taken && !wr_hit)
      valid[wr_idx] <= 1'b1;
  end

  // Payload arrays carry no reset; a cleared valid bit masks their contents.
  always_ff @(posedge clk) begin
    if (i_upd_valid) begin
      if (wr_hit) begin
        if (i_upd_taken) begin
          ctr_mem[wr_idx]    <= (ctr_mem[wr_idx] == 2'd3) ? 2'd3 : ctr_mem[wr_idx] + 2'd1;
          target_mem[wr_idx] <= i_upd_target;
        end else begin
          ctr_mem[wr_idx]    <= (ctr_mem[wr_idx] == 2'd0) ? 2'd0 : ctr_mem[wr_idx] - 2'd1;
        end
      end else if (i_upd_taken) begin
        tag_mem[wr_idx]    <= wr_tag;
        target_mem[wr_idx] <= i_upd_target;
        ctr_mem[wr_idx]    <= CTR_INIT;
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit_btb.sv
// Self-checking bench for fetch_unit_btb: directed scenarios plus a randomized run
// against a per-index table model of the BTB and the fetch PC.
module tb_fetch_unit_btb;

  localparam int AW    = 26;
  localparam int DEPTH = 16;
  localparam int unsigned MASK = (32'd1 << AW) - 32'd1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          i_stall, i_load_we, i_upd_valid, i_upd_taken;
  logic [AW-1:0] i_load_pc, i_upd_pc, i_upd_target;
  logic [AW-1:0] o_pc_current, o_pc_next, o_pred_target;
  logic          o_pred_taken;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  fetch_unit_btb #(
    .ADDR_WIDTH (AW),
    .BTB_DEPTH  (DEPTH),
    .RESET_PC   ('0),
    .CTR_INIT   (2'b10)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_stall       (i_stall),
    .i_load_we     (i_load_we),
    .i_load_pc     (i_load_pc),
    .i_upd_valid   (i_upd_valid),
    .i_upd_pc      (i_upd_pc),
    .i_upd_target  (i_upd_target),
    .i_upd_taken   (i_upd_taken),
    .o_pc_current  (o_pc_current),
    .o_pc_next     (o_pc_next),
    .o_pred_taken  (o_pred_taken),
    .o_pred_target (o_pred_target)
  );

  always #5 clk = ~clk;

  // Reference model: a table keyed by word-index, holding tag, target and counter as integers.
  int unsigned m_pc;
  bit          m_valid [DEPTH];
  int unsigned m_tag   [DEPTH];
  int unsigned m_tgt   [DEPTH];
  int          m_ctr   [DEPTH];

  function automatic int unsigned idx_of(int unsigned pc);
    return (pc / 4) % DEPTH;
  endfunction

  function automatic int unsigned tag_of(int unsigned pc);
    return pc / (4 * DEPTH);
  endfunction

  function automatic bit m_hit(int unsigned pc);
    return m_valid[idx_of(pc)] && (m_tag[idx_of(pc)] == tag_of(pc));
  endfunction

  function automatic bit m_pred();
    return m_hit(m_pc) && (m_ctr[idx_of(m_pc)] >= 2);
  endfunction

  function automatic int unsigned m_ptgt();
    return m_pred() ? m_tgt[idx_of(m_pc)] : 0;
  endfunction

  function automatic int unsigned m_next();
    if (i_load_we)   return int'(i_load_pc);
    if (i_stall)     return m_pc;
    if (m_pred())    return m_ptgt();
    return (m_pc + 4) & MASK;
  endfunction

  task automatic m_reset();
    m_pc = 0;
    for (int i = 0; i < DEPTH; i++) m_valid[i] = 1'b0;
  endtask

  task automatic idle();
    i_stall = 0; i_load_we = 0; i_load_pc = '0;
    i_upd_valid = 0; i_upd_pc = '0; i_upd_target = '0; i_upd_taken = 0;
  endtask

  // Advance one clock; the model is updated from the pre-edge inputs and state.
  task automatic tick();
    int unsigned nxt, i, pc;
    nxt = m_next();
    pc  = int'(i_upd_pc);
    i   = idx_of(pc);
    if (i_upd_valid) begin
      if (m_hit(pc)) begin
        if (i_upd_taken) begin
          m_ctr[i] = (m_ctr[i] < 3) ? m_ctr[i] + 1 : 3;
          m_tgt[i] = int'(i_upd_target);
        end else begin
          m_ctr[i] = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
        end
      end else if (i_upd_taken) begin
        m_valid[i] = 1'b1;
        m_tag[i]   = tag_of(pc);
        m_tgt[i]   = int'(i_upd_target);
        m_ctr[i]   = 2;
      end
    end
    @(posedge clk);
    m_pc = nxt;
    #1;
  endtask

  task automatic redirect(input int unsigned pc);
    idle();
    i_load_we = 1; i_load_pc = AW'(pc);
    tick();
    idle();
    #1;
  endtask

  task automatic update(input int unsigned pc, input int unsigned tgt, input bit taken);
    idle();
    i_upd_valid = 1; i_upd_pc = AW'(pc); i_upd_target = AW'(tgt); i_upd_taken = taken;
    tick();
    idle();
  endtask

  task automatic test_reset();
    idle();
    #2 rst_n = 0;
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    n_tests++;
    if (o_pc_current !== AW'(0)) begin n_fail++; $display("FAIL reset_pc got %h want %h", o_pc_current, AW'(0)); end
    n_tests++;
    if (o_pred_taken !== 1'b0 || o_pred_target !== AW'(0)) begin
      n_fail++; $display("FAIL reset_pred got %b/%h want 0/0", o_pred_taken, o_pred_target);
    end
    @(negedge clk);
    rst_n = 1;
    #1;
    n_tests++;
    if (o_pc_current !== AW'(0)) begin n_fail++; $display("FAIL release_pc got %h want 0", o_pc_current); end
    for (int k = 1; k <= 3; k++) begin
      tick();
      n_tests++;
      if (o_pc_current !== AW'(4 * k) || o_pred_taken !== 1'b0) begin
        n_fail++; $display("FAIL seq_pc%0d got %h/%b want %h/0", k, o_pc_current, o_pred_taken, AW'(4 * k));
      end
    end
  endtask

  task automatic test_stall_redirect();
    tick();
    n_tests++;
    if (o_pc_current !== AW'('h10)) begin n_fail++; $display("FAIL pc_0x10 got %h want 010", o_pc_current); end
    i_stall = 1;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_tests++;
      if (o_pc_current !== AW'('h10)) begin n_fail++; $display("FAIL stall_hold%0d got %h want 010", k, o_pc_current); end
    end
    i_load_we = 1; i_load_pc = AW'('h200);
    #1;
    n_tests++;
    if (o_pc_next !== AW'('h200)) begin n_fail++; $display("FAIL redirect_over_stall_next got %h want 200", o_pc_next); end
    tick();
    idle();
    n_tests++;
    if (o_pc_current !== AW'('h200)) begin n_fail++; $display("FAIL redirect_over_stall got %h want 200", o_pc_current); end
  endtask

  task automatic test_allocate();
    update('h40, 'h100, 1);
    redirect('h40);
    n_tests++;
    if (o_pred_taken !== 1'b1 || o_pred_target !== AW'('h100) || o_pc_next !== AW'('h100)) begin
      n_fail++; $display("FAIL alloc_pred got %b/%h/%h want 1/100/100", o_pred_taken, o_pred_target, o_pc_next);
    end
    tick();
    n_tests++;
    if (o_pc_current !== AW'('h100)) begin n_fail++; $display("FAIL alloc_follow got %h want 100", o_pc_current); end
  endtask

  task automatic test_counters();
    update('h40, 'h100, 1);
    update('h40, 'h100, 1);
    update('h40, 'h100, 0);
    redirect('h40);
    n_tests++;
    if (o_pred_taken !== 1'b1 || o_pred_target !== AW'('h100)) begin
      n_fail++; $display("FAIL hyst_ctr2 got %b/%h want 1/100", o_pred_taken, o_pred_target);
    end
    // Not-taken update while looking up the same entry: lookup sees pre-update state.
    i_upd_valid = 1; i_upd_pc = AW'('h40); i_upd_taken = 0; i_upd_target = AW'('h999);
    #1;
    n_tests++;
    if (o_pred_taken !== 1'b1 || o_pc_next !== AW'('h100)) begin
      n_fail++; $display("FAIL no_bypass got %b/%h want 1/100", o_pred_taken, o_pc_next);
    end
    tick();
    idle();
    redirect('h40);
    n_tests++;
    if (o_pred_taken !== 1'b0 || o_pred_target !== AW'(0) || o_pc_next !== AW'('h44)) begin
      n_fail++; $display("FAIL hyst_ctr1 got %b/%h/%h want 0/0/44", o_pred_taken, o_pred_target, o_pc_next);
    end
  endtask

  task automatic test_alias();
    update('h440, 'h100, 1);
    redirect('h40);
    n_tests++;
    if (o_pred_taken !== 1'b0 || o_pc_next !== AW'('h44)) begin
      n_fail++; $display("FAIL alias_old_miss got %b/%h want 0/44", o_pred_taken, o_pc_next);
    end
    redirect('h440);
    n_tests++;
    if (o_pred_taken !== 1'b1 || o_pred_target !== AW'('h100)) begin
      n_fail++; $display("FAIL alias_new_hit got %b/%h want 1/100", o_pred_taken, o_pred_target);
    end
    update('h80, 'h300, 0);
    redirect('h80);
    n_tests++;
    if (o_pred_taken !== 1'b0) begin n_fail++; $display("FAIL nt_no_alloc got %b want 0", o_pred_taken); end
  endtask

  task automatic test_async_reset_wrap();
    redirect('h440);
    #2 rst_n = 0;
    #1;
    n_tests++;
    if (o_pc_current !== AW'(0) || o_pred_taken !== 1'b0) begin
      n_fail++; $display("FAIL async_reset got %h/%b want 0/0", o_pc_current, o_pred_taken);
    end
    #1 rst_n = 1;
    m_reset();
    redirect('h440);
    n_tests++;
    if (o_pred_taken !== 1'b0) begin n_fail++; $display("FAIL reset_clears_btb got %b want 0", o_pred_taken); end
    redirect('h3FFFFFC);
    n_tests++;
    if (o_pc_current !== AW'('h3FFFFFC) || o_pc_next !== AW'(0)) begin
      n_fail++; $display("FAIL wrap_next got %h/%h want 3fffffc/0", o_pc_current, o_pc_next);
    end
    tick();
    n_tests++;
    if (o_pc_current !== AW'(0)) begin n_fail++; $display("FAIL wrap_pc got %h want 0", o_pc_current); end
  endtask

  task automatic test_random();
    int unsigned exp_next, exp_tgt;
    bit exp_pred;
    int unsigned errs;
    errs = 0;
    for (int k = 0; k < 400; k++) begin
      idle();
      i_stall   = ($urandom_range(0, 99) < 20);
      i_load_we = ($urandom_range(0, 99) < 12);
      i_load_pc = AW'($urandom_range(0, 511) * 4);
      if ($urandom_range(0, 99) < 45) begin
        i_upd_valid  = 1;
        i_upd_pc     = ($urandom_range(0, 1) == 1) ? AW'(m_pc | $urandom_range(0, 3))
                                                    : AW'($urandom_range(0, 2047));
        i_upd_target = AW'($urandom_range(0, 511) * 4);
        i_upd_taken  = ($urandom_range(0, 99) < 65);
      end
      #1;
      exp_pred = m_pred();
      exp_tgt  = m_ptgt();
      exp_next = m_next();
      n_tests++;
      if (o_pc_current !== AW'(m_pc) || o_pred_taken !== exp_pred ||
          o_pred_target !== AW'(exp_tgt) || o_pc_next !== AW'(exp_next)) begin
        n_fail++;
        if (errs < 10)
          $display("FAIL rand%0d got pc=%h pred=%b tgt=%h next=%h want pc=%h pred=%b tgt=%h next=%h",
                   k, o_pc_current, o_pred_taken, o_pred_target, o_pc_next,
                   AW'(m_pc), exp_pred, AW'(exp_tgt), AW'(exp_next));
        errs++;
      end
      tick();
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_stall_redirect();
    test_allocate();
    test_counters();
    test_alias();
    test_async_reset_wrap();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got running want finished");
    $fatal(1, "timeout");
  end

endmodule
